pll_phase_stepper: RTL and testbench

//  Drives the dynamic-phase-shift port (phase_en/updn/cntsel/phase_done) of an altera_pll
//  DPS-subtype instance on behalf of N_CNT output counters. Turns signed multi-step requests

---
 rtl/pll_phase_stepper.sv | 206 ++++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_stepper.sv
// Dynamic-phase-shift sequencer for an altera_pll DPS port: splits signed multi-step requests
// into single phase_en pulses, handles phase_done/timeout/lock loss and tracks per-counter phase.
module pll_phase_stepper #(
    parameter int N_CNT            = 4,
    parameter int STEP_W           = 8,
    parameter int STEPS_PER_PERIOD = 24,
    parameter int PHASE_W          = 5,
    parameter int PULSE_CYC        = 2,
    parameter int TIMEOUT_CYC      = 255,
    localparam int IW              = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
    input  logic               scanclk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IW-1:0]      req_cnt,
    input  logic [STEP_W-1:0]  req_steps,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic               err_unlocked,
    input  logic [IW-1:0]      rd_cnt,
    output logic [PHASE_W-1:0] rd_phase,
    input  logic               pll_locked,
    input  logic               pll_phase_done,
    output logic               pll_phase_en,
    output logic               pll_updn,
    output logic [4:0]         pll_cntsel
);

    localparam int PC_W   = $clog2(PULSE_CYC + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int N_SLOT = 1 << IW;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT_LO,
        WAIT_HI,
        STEP
    } state_t;

    state_t              state;
    logic                locked_s1, locked_s2;
    logic                pd_s1, pd_s2;
    logic [IW-1:0]       cnt;
    logic [STEP_W:0]     remaining;
    logic [PC_W-1:0]     pulse_cnt;
    logic [TO_W-1:0]     wait_cnt;
    logic [PHASE_W-1:0]  phase [N_SLOT];

    logic                req_sign;
    logic [STEP_W:0]     req_ext;
    logic [STEP_W:0]     req_mag;
    logic                req_cnt_ok;
    logic                rd_cnt_ok;
    logic                transfer;

    // One extra magnitude bit so the most negative request still has a representable count.
    always_comb begin
        req_sign   = req_steps[STEP_W-1];
        req_ext    = {req_sign, req_steps};
        req_mag    = req_sign ? -req_ext : req_ext;
        req_cnt_ok = {1'b0, req_cnt} < (IW+1)'(N_CNT);
        rd_cnt_ok  = {1'b0, rd_cnt} < (IW+1)'(N_CNT);
    end

    assign req_ready = (state == IDLE) && locked_s2;
    assign busy      = (state != IDLE);
    assign transfer  = req_valid && req_ready;

    function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] p,
                                                      input logic up);
        if (up)
            return (p == PHASE_W'(STEPS_PER_PERIOD - 1)) ? '0 : p + 1'b1;
        else
            return (p == '0) ? PHASE_W'(STEPS_PER_PERIOD - 1) : p - 1'b1;
    endfunction

    always_ff @(posedge scanclk) begin
        if (rst) begin
            locked_s1 <= 1'b0;
            locked_s2 <= 1'b0;
            pd_s1     <= 1'b0;
            pd_s2     <= 1'b0;
        end else begin
            locked_s1 <= pll_locked;
            locked_s2 <= locked_s1;
            pd_s1     <= pll_phase_done;
            pd_s2     <= pd_s1;
        end
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            remaining    <= '0;
            pulse_cnt    <= '0;
            wait_cnt     <= '0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_unlocked <= 1'b0;
            pll_phase_en <= 1'b0;
            pll_updn     <= 1'b0;
            pll_cntsel   <= '0;
            for (int unsigned i = 0; i < N_SLOT; i++)
                phase[i] <= '0;
        end else begin
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_unlocked <= 1'b0;

            // The PLL realigns all counters after relock, so tracked phases restart at zero.
            if (!locked_s2) begin
                for (int unsigned i = 0; i < N_SLOT; i++)
                    phase[i] <= '0;
            end

            if (state != IDLE && !locked_s2) begin
                err_unlocked <= 1'b1;
                pll_phase_en <= 1'b0;
                pll_updn     <= 1'b0;
                pll_cntsel   <= '0;
                state        <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (transfer) begin
                            cnt       <= req_cnt;
                            remaining <= req_mag;
                            if (!req_cnt_ok || req_steps == '0) begin
                                done <= 1'b1;
                            end else begin
                                pll_cntsel <= 5'(req_cnt);
                                pll_updn   <= ~req_sign;
                                state      <= SETUP;
                            end
                        end
                    end
                    SETUP: begin
                        pll_phase_en <= 1'b1;
                        pulse_cnt    <= '0;
                        state        <= PULSE;
                    end
                    PULSE: begin
                        if (pulse_cnt == PC_W'(PULSE_CYC - 1)) begin
                            pll_phase_en <= 1'b0;
                            wait_cnt     <= '0;
                            state        <= WAIT_LO;
                        end else begin
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end
                    end
                    WAIT_LO: begin
                        if (!pd_s2) begin
                            wait_cnt <= '0;
                            state    <= WAIT_HI;
                        end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            err_timeout <= 1'b1;
                            pll_updn    <= 1'b0;
                            pll_cntsel  <= '0;
                            state       <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    WAIT_HI: begin
                        if (pd_s2) begin
                            state <= STEP;
                        end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            err_timeout <= 1'b1;
                            pll_updn    <= 1'b0;
                            pll_cntsel  <= '0;
                            state       <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    STEP: begin
                        phase[cnt] <= phase_step(phase[cnt], pll_updn);
                        remaining  <= remaining - 1'b1;
                        if (remaining == (STEP_W+1)'(1)) begin
                            done       <= 1'b1;
                            pll_updn   <= 1'b0;
                            pll_cntsel <= '0;
                            state      <= IDLE;
                        end else begin
                            state <= SETUP;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge scanclk) begin
        if (rst)
            rd_phase <= '0;
        else
            rd_phase <= rd_cnt_ok ? phase[rd_cnt] : '0;
    end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Bench for pll_phase_stepper: directed table, timeout/lock-loss/reset sequences and random
// requests against a modular-arithmetic phase model with a behavioural PLL phase_done responder.
module tb_pll_phase_stepper;

    // N_CNT=3 so that an out-of-range counter index is representable on the 2-bit select.
    localparam int N_CNT       = 3;
    localparam int STEP_W      = 8;
    localparam int SPP         = 24;
    localparam int PHASE_W     = 5;
    localparam int PULSE_CYC   = 2;
    localparam int TIMEOUT_CYC = 255;
    localparam int IW          = 2;

    logic               scanclk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [IW-1:0]      req_cnt;
    logic [STEP_W-1:0]  req_steps;
    logic               busy, done, err_timeout, err_unlocked;
    logic [IW-1:0]      rd_cnt;
    logic [PHASE_W-1:0] rd_phase;
    logic               pll_locked;
    logic               pll_phase_done;
    logic               pll_phase_en, pll_updn;
    logic [4:0]         pll_cntsel;

    pll_phase_stepper #(
        .N_CNT(N_CNT), .STEP_W(STEP_W), .STEPS_PER_PERIOD(SPP), .PHASE_W(PHASE_W),
        .PULSE_CYC(PULSE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .scanclk(scanclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cnt(req_cnt), .req_steps(req_steps), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_unlocked(err_unlocked), .rd_cnt(rd_cnt),
        .rd_phase(rd_phase), .pll_locked(pll_locked), .pll_phase_done(pll_phase_done),
        .pll_phase_en(pll_phase_en), .pll_updn(pll_updn), .pll_cntsel(pll_cntsel)
    );

    always #5 scanclk = ~scanclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge scanclk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor plus PLL responder: each phase_en rise makes phase_done go low after a
    // short random delay for a random time, unless the PLL is modelled as stuck.
    logic       en_prev = 1'b0;
    int         mon_pulses = 0, mon_bad = 0, hi_len = 0, last_fall_cyc = 0;
    logic       exp_updn = 1'b0;
    logic [4:0] exp_cntsel = '0;
    int         pll_mode = 0;
    int         to_low = 0, low_left = 0;
    bit         pd_active = 0;

    always @(negedge scanclk) begin
        if (pll_phase_en === 1'b1 && !en_prev) begin
            mon_pulses++;
            hi_len = 1;
            if (pll_updn !== exp_updn || pll_cntsel !== exp_cntsel) mon_bad++;
            if (pll_mode == 0) begin
                pd_active = 1;
                to_low    = $urandom_range(0, 2);
                low_left  = $urandom_range(2, 6);
            end
        end else if (pll_phase_en === 1'b1) begin
            hi_len++;
        end else if (en_prev) begin
            last_fall_cyc = cyc;
            if (hi_len != PULSE_CYC) mon_bad++;
        end
        en_prev = (pll_phase_en === 1'b1);
        if (pd_active) begin
            if (to_low > 0) to_low--;
            else if (low_left > 0) begin
                pll_phase_done = 1'b0;
                low_left--;
            end else begin
                pll_phase_done = 1'b1;
                pd_active = 0;
            end
        end
    end

    int ref_ph [N_CNT];

    task automatic start_req(input int c, input int s);
        bit ok;
        @(negedge scanclk);
        mon_pulses = 0;
        mon_bad    = 0;
        exp_cntsel = 5'(c);
        exp_updn   = (s > 0);
        req_cnt    = IW'(c);
        req_steps  = STEP_W'(s);
        req_valid  = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge scanclk);
        end
        if (!ok) check("req_ready_wait", 0, 1);
        else @(posedge scanclk);
        #1 req_valid = 1'b0;
    endtask

    // kind: 1 done, 2 err_timeout, 3 err_unlocked; lat counts negedges after the transfer edge
    task automatic wait_end(output int kind, output int lat, output int end_cyc, output logic end_en);
        kind = 0; lat = 0; end_cyc = 0; end_en = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge scanclk);
            if (done || err_timeout || err_unlocked) begin
                kind    = done ? 1 : (err_timeout ? 2 : 3);
                lat     = i;
                end_cyc = cyc;
                end_en  = pll_phase_en;
                check("end_pulse_exclusive", $countones({done, err_timeout, err_unlocked}), 1);
                break;
            end
        end
        if (kind == 0) check("end_wait_expired", 0, 1);
        @(negedge scanclk);
        check("end_pulse_one_cycle", {done, err_timeout, err_unlocked}, 0);
    endtask

    task automatic read_phase(input int c, output int v);
        @(negedge scanclk);
        rd_cnt = IW'(c);
        @(negedge scanclk);
        v = rd_phase;
    endtask

    task automatic check_all(input string tag);
        int v;
        for (int c = 0; c < (1 << IW); c++) begin
            read_phase(c, v);
            check($sformatf("%s_phase%0d", tag, c), v, (c < N_CNT) ? ref_ph[c] : 0);
        end
    endtask

    function automatic int mod_spp(input int x);
        return ((x % SPP) + SPP) % SPP;
    endfunction

    // Full request expected to complete normally; returns the read-back phase of counter c.
    task automatic run_req(input string tag, input int c, input int s, input int exp_pulses,
                           output int got_phase);
        int kind, lat, ec;
        logic ee;
        start_req(c, s);
        wait_end(kind, lat, ec, ee);
        check({tag, "_kind"}, kind, 1);
        check({tag, "_pulses"}, mon_pulses, exp_pulses);
        check({tag, "_pulse_shape"}, mon_bad, 0);
        if (exp_pulses == 0) check({tag, "_done_latency"}, lat, 0);
        if (c < N_CNT) ref_ph[c] = mod_spp(ref_ph[c] + s);
        read_phase(c, got_phase);
    endtask

    typedef struct {
        int cnt;
        int steps;
        int exp_phase;
        int exp_pulses;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, lat, ec, v, s;
        logic ee;
        bit ok;

        vecs[0] = '{cnt: 1, steps:    3, exp_phase:  3, exp_pulses:   3};
        vecs[1] = '{cnt: 0, steps:   -1, exp_phase: 23, exp_pulses:   1};
        vecs[2] = '{cnt: 0, steps:    1, exp_phase:  0, exp_pulses:   1};
        vecs[3] = '{cnt: 2, steps:    0, exp_phase:  0, exp_pulses:   0};
        vecs[4] = '{cnt: 3, steps:    5, exp_phase:  0, exp_pulses:   0};
        vecs[5] = '{cnt: 2, steps: -128, exp_phase: 16, exp_pulses: 128};
        vecs[6] = '{cnt: 1, steps:   25, exp_phase:  4, exp_pulses:  25};
        vecs[7] = '{cnt: 1, steps:   -4, exp_phase:  0, exp_pulses:   4};

        for (int i = 0; i < N_CNT; i++) ref_ph[i] = 0;
        rst = 1'b1; req_valid = 1'b0; req_cnt = '0; req_steps = '0; rd_cnt = '0;
        pll_locked = 1'b0; pll_phase_done = 1'b1;
        repeat (3) @(negedge scanclk);
        check("reset_outputs",
              {req_ready, busy, done, err_timeout, err_unlocked, rd_phase,
               pll_phase_en, pll_updn, pll_cntsel}, 0);
        rst = 1'b0;
        pll_locked = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].steps, vecs[i].exp_pulses, v);
            check($sformatf("vec%0d_phase", i), v, vecs[i].exp_phase);
        end
        check_all("after_table");

        // Stuck phase_done: first step must time out exactly TIMEOUT_CYC after WAIT_LO entry.
        pll_mode = 1;
        start_req(0, 2);
        wait_end(kind, lat, ec, ee);
        check("timeout_kind", kind, 2);
        check("timeout_cycles", ec - last_fall_cyc, TIMEOUT_CYC);
        check("timeout_pulses", mon_pulses, 1);
        check("timeout_ready", req_ready, 1);
        pll_mode = 0;
        check_all("after_timeout");

        // Lock loss during the second step of a +5 request.
        ref_ph[0] = 5; ref_ph[1] = 0; ref_ph[2] = 0;
        run_req("preload", 0, 5, 5, v);
        start_req(1, 5);
        for (int i = 0; i < 2000; i++) begin
            if (mon_pulses >= 2) break;
            @(negedge scanclk);
        end
        check("unlock_reached_step2", mon_pulses >= 2, 1);
        pll_locked = 1'b0;
        wait_end(kind, lat, ec, ee);
        check("unlock_kind", kind, 3);
        check("unlock_phase_en", ee, 0);
        for (int i = 0; i < N_CNT; i++) ref_ph[i] = 0;
        check_all("unlocked");
        check("unlock_ready_low", req_ready, 0);
        repeat (20) @(negedge scanclk);
        check("unlock_ready_still_low", req_ready, 0);
        pll_locked = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge scanclk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        check("relock_ready", ok, 1);
        check_all("relocked");

        // Synchronous reset in the middle of a request.
        run_req("pre_rst", 2, 7, 7, v);
        check("pre_rst_phase", v, 7);
        start_req(2, 10);
        for (int i = 0; i < 2000; i++) begin
            if (pll_phase_en) break;
            @(negedge scanclk);
        end
        rst = 1'b1;
        @(negedge scanclk);
        check("rst_midop_outputs", {pll_phase_en, busy, pll_cntsel, pll_updn}, 0);
        @(negedge scanclk);
        rst = 1'b0;
        for (int i = 0; i < N_CNT; i++) ref_ph[i] = 0;
        check_all("after_rst");
        repeat (20) @(negedge scanclk);

        // Random requests against the modular phase model.
        for (int n = 0; n < 30; n++) begin
            int c;
            c = $urandom_range(0, 3);
            s = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 60)) - 30;
            run_req($sformatf("rnd%0d", n), c, s, (c < N_CNT) ? ((s < 0) ? -s : s) : 0, v);
            check($sformatf("rnd%0d_phase", n), v, (c < N_CNT) ? ref_ph[c] : 0);
        end
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
